// File: rtl/rec_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rec_player_pkg
// Description : Shared constants and helpers for the record player block.
//               Field widths of the record memory and Sound interface, the
//               record-memory entry layout and the playback-length clamp.
// Ports       : none (package)
// Config      : REC_PLAYER_LOOP_EN is consumed by rec_player, not here
// Revision    : 1.0 - initial release
// ============================================================================
package rec_player_pkg;

  localparam int OCTAVE_BITS   = 3;
  localparam int NOTE_BITS     = 4;
  localparam int LENGTH_BITS   = 3;
  localparam int NOTE_KEY_BITS = 7;
  localparam int REC_CNT_BITS  = 5;

  // Number of addressable record-memory entries.
  localparam int REC_DEPTH = 1 << REC_CNT_BITS;

  // One record-memory entry as presented on the read port.
  typedef struct packed {
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] length;
  } note_entry_t;

  // rec_len is one bit wider than the address so it can name a full memory;
  // anything beyond the memory depth is clamped so playback never wraps the
  // address and replays early entries.
  function automatic logic [REC_CNT_BITS:0] clamp_len(input logic [REC_CNT_BITS:0] len);
    logic [REC_CNT_BITS:0] depth;
    depth = (REC_CNT_BITS+1)'(REC_DEPTH);
    return (len > depth) ? depth : len;
  endfunction

endpackage : rec_player_pkg
`default_nettype wire

// File: rtl/rec_player_light.sv
`default_nettype none
// ============================================================================
// Module      : rec_player_light
// Description : Light decoder. Maps a note code to a one-hot key LED
//               vector: note 1..NOTE_KEY_BITS lights key (note-1); note 0
//               (rest) and codes above the key count light nothing.
// Ports       : note [NOTE_BITS-1:0]     in  - note code
//               led  [NOTE_KEY_BITS-1:0] out - one-hot key LEDs
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module rec_player_light
  import rec_player_pkg::*;
(
  input  logic [NOTE_BITS-1:0]     note,
  output logic [NOTE_KEY_BITS-1:0] led
);

  for (genvar k = 0; k < NOTE_KEY_BITS; k++) begin : g_key
    assign led[k] = (note == NOTE_BITS'(k + 1));
  end

endmodule : rec_player_light
`default_nettype wire

// File: rtl/rec_player.sv
`default_nettype none
// ============================================================================
// Module      : rec_player
// Description : Plays back a recorded note sequence. Each entry is fetched
//               from the record memory, handed to the Sound block, held until
//               Sound reports the note finished, then followed by a silent
//               gap of GAP_CYCLES clocks (frozen while pause is high).
// Ports       : clk, rst (async, active-high)
//               en, start (rising edge), pause (level)
//               rec_len [REC_CNT_BITS:0]        - recorded entry count
//               rd_en, rd_addr                  - record-memory read request
//               rd_octave, rd_note, rd_length   - read data, 1 cycle after rd_en
//               snd_en, snd_octave, snd_note, snd_length - Sound request
//               snd_over                        - Sound idle/finished
//               playing, done (1-cycle pulse), note_led (one-hot)
// Config      : REC_PLAYER_LOOP_EN - when defined, playback wraps to entry 0
//               after the last entry and runs until en=0 or rst.
// Revision    : 1.0 - initial release
// ============================================================================
module rec_player
  import rec_player_pkg::*;
#(
  parameter int GAP_CYCLES = 1000  // silent cycles between notes, >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     pause,
  input  logic [REC_CNT_BITS:0]    rec_len,
  output logic                     rd_en,
  output logic [REC_CNT_BITS-1:0]  rd_addr,
  input  logic [OCTAVE_BITS-1:0]   rd_octave,
  input  logic [NOTE_BITS-1:0]     rd_note,
  input  logic [LENGTH_BITS-1:0]   rd_length,
  output logic                     snd_en,
  output logic [OCTAVE_BITS-1:0]   snd_octave,
  output logic [NOTE_BITS-1:0]     snd_note,
  output logic [LENGTH_BITS-1:0]   snd_length,
  input  logic                     snd_over,
  output logic                     playing,
  output logic                     done,
  output logic [NOTE_KEY_BITS-1:0] note_led
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    PLAY   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                  state;
  logic                    start_q;
  logic [REC_CNT_BITS-1:0] index;
  logic [REC_CNT_BITS:0]   eff_len;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    armed;

  logic                    start_rise;
  logic [REC_CNT_BITS:0]   last_full;
  logic [REC_CNT_BITS-1:0] last_idx;
  logic [NOTE_KEY_BITS-1:0] led_dec;
  note_entry_t             rd_entry;

  assign start_rise = start & ~start_q;
  // eff_len is at least 1 whenever the FSM is past IDLE, so no underflow.
  assign last_full  = eff_len - 1'b1;
  assign last_idx   = last_full[REC_CNT_BITS-1:0];
  assign rd_entry   = '{octave: rd_octave, note: rd_note, length: rd_length};

  rec_player_light u_light (
    .note (rd_entry.note),
    .led  (led_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      index      <= '0;
      eff_len    <= '0;
      gap_cnt    <= '0;
      armed      <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      snd_en     <= 1'b0;
      snd_octave <= '0;
      snd_note   <= '0;
      snd_length <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
      note_led   <= '0;
    end else begin
      start_q <= start;

      if (!en) begin
        // Disable wins over everything, including a start edge this cycle.
        state    <= IDLE;
        rd_en    <= 1'b0;
        snd_en   <= 1'b0;
        note_led <= '0;
        done     <= 1'b0;
        playing  <= 1'b0;
        armed    <= 1'b0;
        gap_cnt  <= '0;
      end else begin
        rd_en <= 1'b0;
        done  <= 1'b0;

        case (state)
          IDLE: begin
            if (start_rise) begin
              playing <= 1'b1;
              if (rec_len != '0) begin
                index   <= '0;
                eff_len <= clamp_len(rec_len);
                rd_en   <= 1'b1;
                rd_addr <= '0;
                state   <= FETCH;
              end else begin
                done     <= 1'b1;
                note_led <= '0;
                state    <= FINISH;
              end
            end
          end

          // rd_en is high for exactly this one state cycle.
          FETCH: begin
            state <= LOAD;
          end

          LOAD: begin
            snd_octave <= rd_entry.octave;
            snd_note   <= rd_entry.note;
            snd_length <= rd_entry.length;
            note_led   <= led_dec;
            snd_en     <= 1'b1;
            armed      <= 1'b0;
            state      <= PLAY;
          end

          // Sound may still show idle (over=1) when the request goes out;
          // the note only ends after over has been seen low at least once.
          PLAY: begin
            if (!snd_over) begin
              armed <= 1'b1;
            end else if (armed) begin
              snd_en  <= 1'b0;
              armed   <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end

          GAP: begin
            if (!pause) begin
              if (gap_cnt == GAP_LAST) begin
                gap_cnt <= '0;
                if (index == last_idx) begin
`ifdef REC_PLAYER_LOOP_EN
                  // End of a pass: report it and start over at entry 0.
                  done    <= 1'b1;
                  index   <= '0;
                  rd_addr <= '0;
                  rd_en   <= 1'b1;
                  state   <= FETCH;
`else
                  done     <= 1'b1;
                  note_led <= '0;
                  state    <= FINISH;
`endif
                end else begin
                  index   <= index + 1'b1;
                  rd_addr <= index + 1'b1;
                  rd_en   <= 1'b1;
                  state   <= FETCH;
                end
              end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
              end
            end
          end

          // done is high during this state; it and playing fall together.
          FINISH: begin
            note_led <= '0;
            playing  <= 1'b0;
            state    <= IDLE;
          end

          default: begin
            snd_en   <= 1'b0;
            note_led <= '0;
            playing  <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : rec_player
`default_nettype wire

// File: tb/tb_rec_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_rec_player
// Description : Scoreboard bench for rec_player with GAP_CYCLES=4, a
//               registered record-memory model and a Sound model whose
//               over output goes low for 10 cycles after each snd_en rise.
//               Expected read addresses and Sound requests are queued by the
//               stimulus; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rec_player;

  localparam int GAP   = 4;
  localparam int WIN   = 12;  // snd_en high cycles per note with this Sound model
  localparam int PER   = 18;  // cycles between successive rd_en pulses

  logic       clk, rst, en, start, pause;
  logic [5:0] rec_len;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [2:0] rd_octave;
  logic [3:0] rd_note;
  logic [2:0] rd_length;
  logic       snd_en;
  logic [2:0] snd_octave;
  logic [3:0] snd_note;
  logic [2:0] snd_length;
  logic       snd_over;
  logic       playing, done;
  logic [6:0] note_led;

  rec_player #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .pause(pause),
    .rec_len(rec_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_octave(rd_octave), .rd_note(rd_note), .rd_length(rd_length),
    .snd_en(snd_en), .snd_octave(snd_octave), .snd_note(snd_note),
    .snd_length(snd_length), .snd_over(snd_over),
    .playing(playing), .done(done), .note_led(note_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference content ----------------
  function automatic int m_oct(input int i);  return i % 8;       endfunction
  function automatic int m_note(input int i); return (i * 3) % 8; endfunction
  function automatic int m_len(input int i);  return (i + 1) % 8; endfunction
  function automatic int led_of(input int n);
    return (n >= 1 && n <= 7) ? (1 << (n - 1)) : 0;
  endfunction

  // Record memory: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_octave <= 3'(m_oct(int'(rd_addr)));
      rd_note   <= 4'(m_note(int'(rd_addr)));
      rd_length <= 3'(m_len(int'(rd_addr)));
    end
  end

  // Sound model.
  logic over_m, snd_en_q, force_en, force_val;
  int   ocnt;
  initial begin over_m = 1'b1; snd_en_q = 1'b0; ocnt = 0; end
  always @(posedge clk) begin
    snd_en_q <= snd_en;
    if (snd_en && !snd_en_q) begin
      over_m <= 1'b0;
      ocnt   <= 10;
    end else if (ocnt > 1) begin
      ocnt <= ocnt - 1;
    end else if (ocnt == 1) begin
      over_m <= 1'b1;
      ocnt   <= 0;
    end
  end
  assign snd_over = force_en ? force_val : over_m;

  // ---------------- scoreboard ----------------
  typedef struct {int oct; int note; int len; int led; int win;} snd_exp_t;
  int       exp_addr[$];
  snd_exp_t exp_snd[$];
  int       rd_times[$];
  int       checks = 0, failures = 0;
  int       done_cnt = 0, cyc = 0, win_start = 0;
  logic     snd_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void push_entry(input int i, input int win);
    snd_exp_t e;
    exp_addr.push_back(i);
    e.oct = m_oct(i); e.note = m_note(i); e.len = m_len(i);
    e.led = led_of(m_note(i)); e.win = win;
    exp_snd.push_back(e);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      snd_prev = 1'b0;
    end else begin
      if (rd_en) begin
        rd_times.push_back(cyc);
        if (exp_addr.size() == 0) begin
          chk("unexpected_rd", int'(rd_addr), -1);
        end else begin
          chk("rd_addr", int'(rd_addr), exp_addr.pop_front());
        end
      end
      if (snd_en && !snd_prev) begin
        win_start = cyc;
        if (exp_snd.size() == 0) begin
          chk("unexpected_snd", int'(snd_note), -1);
        end else begin
          chk("snd_fields",
              {int'(snd_octave), int'(snd_note), int'(snd_length), int'(note_led)} == 0 ? 0 :
              (int'(snd_octave) * 4096 + int'(snd_note) * 256 + int'(snd_length) * 128 + int'(note_led)),
              exp_snd[0].oct * 4096 + exp_snd[0].note * 256 + exp_snd[0].len * 128 + exp_snd[0].led);
        end
      end
      if (!snd_en && snd_prev && exp_snd.size() != 0) begin
        snd_exp_t e;
        e = exp_snd.pop_front();
        if (e.win >= 0) chk("snd_window", cyc - win_start, e.win);
      end
      if (done) done_cnt++;
      snd_prev = snd_en;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_snd(input logic v, input int budget);
    int n = 0;
    while (snd_en !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (snd_en !== v) chk("timeout_snd_en", int'(snd_en), int'(v));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("timeout_done", int'(done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_playing"}, int'(playing), 0);
    chk({tag, "_done"},    int'(done),    0);
    chk({tag, "_snd_en"},  int'(snd_en),  0);
    chk({tag, "_rd_en"},   int'(rd_en),   0);
    chk({tag, "_led"},     int'(note_led), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dbase, rbase;
    rst = 1'b1; en = 1'b0; start = 1'b0; pause = 1'b0; rec_len = '0;
    force_en = 1'b0; force_val = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_snd_note", int'(snd_note), 0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);

    // Three-entry playback; a start edge mid-note must be ignored.
    rec_len = 6'd3; dbase = done_cnt; rbase = rd_times.size();
    for (int i = 0; i < 3; i++) push_entry(i, WIN);
    pulse_start();
    wait_snd(1'b1, 50);
    pulse_start();
    wait_done(300);
    chk("playing_at_done", int'(playing), 1);
    @(negedge clk);
    chk("playing_after_done", int'(playing), 0);
    chk("done_one_cycle", int'(done), 0);
    @(negedge clk);
    chk("done_count_3", done_cnt - dbase, 1);
    chk("reads_3", rd_times.size() - rbase, 3);
    if (rd_times.size() - rbase == 3) begin
      chk("period_0_1", rd_times[rbase+1] - rd_times[rbase], PER);
      chk("period_1_2", rd_times[rbase+2] - rd_times[rbase+1], PER);
    end

    // Empty record.
    rec_len = 6'd0; dbase = done_cnt; rbase = rd_times.size();
    pulse_start();
    wait_done(2);
    repeat (3) @(negedge clk);
    chk("empty_done", done_cnt - dbase, 1);
    chk("empty_reads", rd_times.size() - rbase, 0);
    chk("empty_playing", int'(playing), 0);

    // Pause during PLAY (no effect) then 20 cycles into GAP.
    rec_len = 6'd2; dbase = done_cnt; rbase = rd_times.size();
    push_entry(0, WIN); push_entry(1, WIN);
    pulse_start();
    wait_snd(1'b1, 50);
    pause = 1'b1;
    wait_snd(1'b0, 50);
    repeat (20) @(negedge clk);
    pause = 1'b0;
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("pause_reads", rd_times.size() - rbase, 2);
    if (rd_times.size() - rbase == 2)
      chk("pause_period", rd_times[rbase+1] - rd_times[rbase], PER + 20);
    chk("pause_done", done_cnt - dbase, 1);

    // Start edge coinciding with en falling.
    rbase = rd_times.size();
    en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_en_low_playing", int'(playing), 0);
    chk("start_en_low_reads", rd_times.size() - rbase, 0);
    en = 1'b1;
    @(negedge clk);

    // en dropped while entry 1 plays, then replay from address 0.
    rec_len = 6'd3; dbase = done_cnt;
    push_entry(0, WIN); push_entry(1, -1);
    pulse_start();
    wait_snd(1'b1, 50); wait_snd(1'b0, 50); wait_snd(1'b1, 50);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_all_zero("en_drop");
    repeat (15) @(negedge clk);
    chk("en_drop_no_done", done_cnt - dbase, 0);
    en = 1'b1; rec_len = 6'd1;
    push_entry(0, WIN);
    pulse_start();
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("replay_done", done_cnt - dbase, 1);

    // Asynchronous reset in GAP.
    rec_len = 6'd2; dbase = done_cnt;
    push_entry(0, WIN);
    pulse_start();
    wait_snd(1'b1, 50); wait_snd(1'b0, 50);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_gap");
    chk("rst_gap_addr", int'(rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr.delete(); exp_snd.delete();
    @(negedge clk);
    chk("rst_gap_no_done", done_cnt - dbase, 0);

    // Asynchronous reset mid-note.
    rec_len = 6'd1;
    push_entry(0, -1);
    pulse_start();
    wait_snd(1'b1, 50);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_note_snd_en", int'(snd_en), 0);
    chk("rst_note_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr.delete(); exp_snd.delete();
    @(negedge clk);

    // snd_over already high when PLAY begins.
    force_en = 1'b1; force_val = 1'b1;
    rec_len = 6'd1; dbase = done_cnt;
    push_entry(0, -1);
    pulse_start();
    wait_snd(1'b1, 50);
    repeat (20) @(negedge clk);
    chk("over_high_holds", int'(snd_en), 1);
    force_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_low_holds", int'(snd_en), 1);
    force_val = 1'b1;
    @(negedge clk);
    chk("over_rise_ends", int'(snd_en), 0);
    force_en = 1'b0;
    wait_done(50);
    repeat (2) @(negedge clk);
    chk("over_done", done_cnt - dbase, 1);

    // rec_len beyond memory depth.
    rec_len = 6'd40; dbase = done_cnt; rbase = rd_times.size();
    for (int i = 0; i < 32; i++) push_entry(i, WIN);
`ifdef REC_PLAYER_LOOP_EN
    exp_addr.push_back(0);
`endif
    pulse_start();
    wait_done(1500);
    @(negedge clk);
`ifdef REC_PLAYER_LOOP_EN
    en = 1'b0;
    @(negedge clk);
    chk("len40_reads", rd_times.size() - rbase, 33);
    en = 1'b1;
`else
    chk("len40_reads", rd_times.size() - rbase, 32);
`endif
    @(negedge clk);
    chk("len40_done", done_cnt - dbase, 1);

    repeat (5) @(negedge clk);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("snd_queue_empty", exp_snd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rec_player
`default_nettype wire
